multi_cycle_control: RTL and testbench
======================================

# multi_cycle_control

Finite-state controller that sequences the existing CPU datapath (PC, instruction memory, register file, ALU, data memory, write-back muxes) over multiple clock cycles. It replaces the single-cycle decoder. The instruction register is written only in IF, so each stage's control signals are stable for a full cycle. The block sits beside the datapath: it takes the opcode field and ALU flags and drives every write enable, mux select and ALU operation code.

## Interface
- No parameters; opcode and ALUOp encodings are fixed below.
- CLK  in  1  system clock, all state changes on rising edge
- Reset  in  1  synchronous, active-low reset
- Opcode  in  6  instruction bits [31:26] from the instruction register
- zero  in  1  ALU result == 0
- sign  in  1  ALU result bit 31
- PCWre  out  1  PC loads PCData at the end of this cycle
- IRWre  out  1  instruction register loads at the end of this cycle
- InsMemRW  out  1  instruction memory read enable
- ALUSrcA  out  1  0 = rs data, 1 = zero-extended sa
- ALUSrcB  out  1  0 = rt data, 1 = extended immediate
- ALUOp  out  3  000 add, 001 sub, 010 B<<A, 011 or, 100 and, 101 signed slt
- ExtSel  out  1  0 = zero-extend, 1 = sign-extend immediate
- RegDst  out  1  0 = write rt, 1 = write rd
- RegWre  out  1  register file write enable
- nRD  out  1  data memory read, active low
- nWR  out  1  data memory write, active low
- DBDataSrc  out  1  0 = ALU result, 1 = memory data to write-back
- PCSrc  out  2  00 PC+4, 01 PC+4+(imm<<2), 10 jump target
- state  out  3  current state, for debug display

## Operation
- Opcodes:
  - R-type: add 000000, sub 000001, and 010000, or 010010, sll 011000, slt 100110
  - I-type: addiu 000010, andi 010001, ori 010011, slti 100111
  - Memory: sw 110000, lw 110001
  - Branch/jump: beq 110100, bne 110101, bltz 110110, j 111000, halt 111111
- States and encodings: IF 000, ID 001, EXE_AL 110, EXE_BR 101, EXE_LS 010, MEM 011, WB_AL 111, WB_LD 100, HALT (held as ID encoding with the halt flag; `state` shows 001).
- IF: IRWre=1, InsMemRW=1. Always goes to ID.
- ID: decode the Opcode.
  - ALU ops go to EXE_AL. Branches go to EXE_BR. lw/sw go to EXE_LS.
  - j: PCWre=1, PCSrc=10, next state IF.
  - halt: go to HALT.
  - Undefined opcode: treated as NOP. PCWre=1, PCSrc=00, next state IF.
- EXE_AL: ALUOp per instruction.
  - ALUSrcB=1 for I-type ALU ops.
  - ALUSrcA=1 for sll.
  - ExtSel=1 only for addiu and slti.
  - Next state WB_AL.
- WB_AL: EXE_AL mux/ALU selects held, RegWre=1, RegDst=1 for R-type, DBDataSrc=0, PCWre=1, PCSrc=00. Next state IF.
- EXE_BR: ALUOp=001, ALUSrcB=0, ExtSel=1, PCWre=1, next state IF.
  - PCSrc=01 when taken, otherwise 00.
  - Taken conditions: beq when zero=1, bne when zero=0, bltz when sign=1.
  - zero and sign are sampled combinationally in this cycle.
- EXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1. Next state MEM.
- MEM: EXE_LS selects held.
  - sw: nWR=0, PCWre=1, PCSrc=00, next state IF.
  - lw: nRD=0, next state WB_LD.
- WB_LD: nRD=0, DBDataSrc=1, RegDst=0, RegWre=1, PCWre=1, PCSrc=00. Next state IF.
- HALT: all enables deasserted. Stays in HALT until Reset is low.
- Defaults for any output not listed in a state: 0, except nRD=1 and nWR=1.

## Timing
- Reset low at a rising edge forces the state to IF, including mid-instruction; the partially executed instruction is abandoned.
- While Reset is low, outputs are forced: PCWre=0, IRWre=0, RegWre=0, nRD=1, nWR=1, state=000.
- First cycle after Reset rises: IF with IRWre=1.
- Outputs are Moore-style: decoded from the registered state plus the stable Opcode. The only exception is PCSrc in EXE_BR, which also depends on zero/sign.
- Cycles per instruction: j/NOP 2, branch 3, ALU ops 4, sw 4, lw 5, halt 2 then stall forever.
- PCWre is high for exactly one cycle per instruction, always in its last state. IRWre is high only in IF.
- RegWre and nWR are never active in the same cycle. At most one of the two is active per instruction.
- Opcode changing outside IF is a datapath fault and is not checked.

## Test plan
- Reset held low 3 cycles, then released with Opcode=000000 -> state sequence 000,001,110,111,000. RegWre=1 and RegDst=1 only in the 111 cycle. PCWre pulses once.
- lw (110001) -> states IF,ID,EXE_LS,MEM,WB_LD. nRD=0 in MEM and WB_LD. RegWre=1 only in WB_LD with DBDataSrc=1. Total 5 cycles.
- sw (110000) -> nWR=0 for exactly one cycle (MEM) together with PCWre=1. RegWre never set. Total 4 cycles.
- beq with zero=1 -> EXE_BR shows PCSrc=01. With zero=0 -> PCSrc=00. bne inverts this. bltz with sign=1 -> PCSrc=01.
- j (111000) -> PCSrc=10 and PCWre=1 in ID, back to IF after 2 cycles. Opcode 001111 (undefined) -> NOP, PCSrc=00, 2 cycles.
- halt (111111) -> PCWre stays 0 for 20+ cycles. Reset pulsed low during WB_LD of an lw -> next state IF, RegWre deasserted at once.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU controller: sequences IF/ID/EXE/MEM/WB over the shared
// datapath. Outputs decode from the registered state and the IR opcode.
// Only the branch PC select also looks at the live ALU flags. A low Reset
// forces every enable to its idle level in the same cycle.
module multi_cycle_control (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       RegDst,
  output logic       RegWre,
  output logic       nRD,
  output logic       nWR,
  output logic       DBDataSrc,
  output logic [1:0] PCSrc,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_OR    = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010011;
  localparam logic [5:0] OP_SLTI  = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // ALU operation for the arithmetic/logic instruction group
  function automatic logic [2:0] alu_op_f(input logic [5:0] op);
    case (op)
      OP_SUB:           alu_op_f = 3'b001;
      OP_SLL:           alu_op_f = 3'b010;
      OP_OR,  OP_ORI:   alu_op_f = 3'b011;
      OP_AND, OP_ANDI:  alu_op_f = 3'b100;
      OP_SLT, OP_SLTI:  alu_op_f = 3'b101;
      default:          alu_op_f = 3'b000;
    endcase
  endfunction

  state_t state_q, state_d;
  logic   halt_q,  halt_d;

  logic is_rtype, is_itype, is_alu, is_br, is_mem, br_taken;

  // Opcode class decode
  always_comb begin
    is_rtype = (Opcode == OP_ADD) || (Opcode == OP_SUB) || (Opcode == OP_AND) ||
               (Opcode == OP_OR)  || (Opcode == OP_SLL) || (Opcode == OP_SLT);
    is_itype = (Opcode == OP_ADDIU) || (Opcode == OP_ANDI) ||
               (Opcode == OP_ORI)   || (Opcode == OP_SLTI);
    is_alu   = is_rtype || is_itype;
    is_br    = (Opcode == OP_BEQ) || (Opcode == OP_BNE) || (Opcode == OP_BLTZ);
    is_mem   = (Opcode == OP_SW) || (Opcode == OP_LW);
    br_taken = ((Opcode == OP_BEQ)  &&  zero) ||
               ((Opcode == OP_BNE)  && !zero) ||
               ((Opcode == OP_BLTZ) &&  sign);
  end

  // Next-state selection; HALT reuses the ID encoding with halt_q set
  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    if (!halt_q) begin
      case (state_q)
        S_IF:     state_d = S_ID;
        S_ID: begin
          if (is_alu)                 state_d = S_EXE_AL;
          else if (is_br)             state_d = S_EXE_BR;
          else if (is_mem)            state_d = S_EXE_LS;
          else if (Opcode == OP_HALT) halt_d  = 1'b1;
          else                        state_d = S_IF;
        end
        S_EXE_AL: state_d = S_WB_AL;
        S_EXE_LS: state_d = S_MEM;
        S_MEM:    state_d = (Opcode == OP_LW) ? S_WB_LD : S_IF;
        default:  state_d = S_IF;
      endcase
    end
  end

  // State register with synchronous active-low reset that abandons any instruction
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= S_IF;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  // Control output decode, forced idle while Reset is low or halted
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    ExtSel    = 1'b0;
    RegDst    = 1'b0;
    RegWre    = 1'b0;
    nRD       = 1'b1;
    nWR       = 1'b1;
    DBDataSrc = 1'b0;
    PCSrc     = 2'b00;
    state     = 3'b000;
    if (Reset) begin
      state = state_q;
      if (!halt_q) begin
        case (state_q)
          S_IF: begin
            IRWre    = 1'b1;
            InsMemRW = 1'b1;
          end
          S_ID: begin
            if (Opcode == OP_J) begin
              PCWre = 1'b1;
              PCSrc = 2'b10;
            end else if (!is_alu && !is_br && !is_mem && (Opcode != OP_HALT)) begin
              PCWre = 1'b1;
            end
          end
          S_EXE_AL, S_WB_AL: begin
            ALUOp   = alu_op_f(Opcode);
            ALUSrcA = (Opcode == OP_SLL);
            ALUSrcB = is_itype;
            ExtSel  = (Opcode == OP_ADDIU) || (Opcode == OP_SLTI);
            if (state_q == S_WB_AL) begin
              RegWre = 1'b1;
              RegDst = is_rtype;
              PCWre  = 1'b1;
            end
          end
          S_EXE_BR: begin
            ALUOp  = 3'b001;
            ExtSel = 1'b1;
            PCWre  = 1'b1;
            PCSrc  = br_taken ? 2'b01 : 2'b00;
          end
          S_EXE_LS, S_MEM: begin
            ALUSrcB = 1'b1;
            ExtSel  = 1'b1;
            if (state_q == S_MEM) begin
              if (Opcode == OP_SW) begin
                nWR   = 1'b0;
                PCWre = 1'b1;
              end else begin
                nRD = 1'b0;
              end
            end
          end
          S_WB_LD: begin
            nRD       = 1'b0;
            DBDataSrc = 1'b1;
            RegWre    = 1'b1;
            PCWre     = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: walks each instruction class
// through its states and compares the full control word every cycle.
module tb_multi_cycle_control;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] Opcode = 6'b000000;
  logic       zero = 1'b0;
  logic       sign = 1'b0;
  logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, RegDst, RegWre;
  logic       nRD, nWR, DBDataSrc;
  logic [2:0] ALUOp, state;
  logic [1:0] PCSrc;

  int total = 0;
  int bad   = 0;

  multi_cycle_control dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .zero(zero), .sign(sign),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel), .RegDst(RegDst),
    .RegWre(RegWre), .nRD(nRD), .nWR(nWR), .DBDataSrc(DBDataSrc),
    .PCSrc(PCSrc), .state(state)
  );

  always #5 CLK = ~CLK;

  // Observed control word, same field order as v()
  logic [18:0] obs;
  assign obs = {PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp, ExtSel, RegDst,
                RegWre, nRD, nWR, DBDataSrc, PCSrc, state};

  function automatic logic [18:0] v(input logic pcw, input logic irw, input logic imr,
                                    input logic sa, input logic sb, input logic [2:0] aop,
                                    input logic ext, input logic rdst, input logic rwe,
                                    input logic nrd, input logic nwr, input logic dbs,
                                    input logic [1:0] pcs, input logic [2:0] st);
    return {pcw, irw, imr, sa, sb, aop, ext, rdst, rwe, nrd, nwr, dbs, pcs, st};
  endfunction

  task automatic chk(input string tag, input logic [18:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check this cycle, then move to 1 time unit after the next rising edge
  task automatic cyc(input string tag, input logic [18:0] exp);
    chk(tag, exp);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] V_IF, V_ID, V_IDLE;
    V_IF   = v(0,1,1,0,0,3'b000,0,0,0,1,1,0,2'b00,3'b000);
    V_ID   = v(0,0,0,0,0,3'b000,0,0,0,1,1,0,2'b00,3'b001);
    V_IDLE = v(0,0,0,0,0,3'b000,0,0,0,1,1,0,2'b00,3'b000);

    // Reset held low for 3 cycles, outputs forced idle throughout
    #1;
    chk("rst_t0", V_IDLE);
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_held", V_IDLE);

    // add: IF, ID, EXE_AL, WB_AL
    Reset = 1'b1;
    #1;
    cyc("add_if",  V_IF);
    cyc("add_id",  V_ID);
    cyc("add_exe", v(0,0,0,0,0,3'b000,0,0,0,1,1,0,2'b00,3'b110));
    cyc("add_wb",  v(1,0,0,0,0,3'b000,0,1,1,1,1,0,2'b00,3'b111));

    // lw: 5 cycles, memory read in MEM and WB_LD
    Opcode = 6'b110001;
    cyc("lw_if",  V_IF);
    cyc("lw_id",  V_ID);
    cyc("lw_exe", v(0,0,0,0,1,3'b000,1,0,0,1,1,0,2'b00,3'b010));
    cyc("lw_mem", v(0,0,0,0,1,3'b000,1,0,0,0,1,0,2'b00,3'b011));
    cyc("lw_wb",  v(1,0,0,0,0,3'b000,0,0,1,0,1,1,2'b00,3'b100));

    // sw: 4 cycles, nWR with PCWre in MEM
    Opcode = 6'b110000;
    cyc("sw_if",  V_IF);
    cyc("sw_id",  V_ID);
    cyc("sw_exe", v(0,0,0,0,1,3'b000,1,0,0,1,1,0,2'b00,3'b010));
    cyc("sw_mem", v(1,0,0,0,1,3'b000,1,0,0,1,0,0,2'b00,3'b011));

    // beq: taken with zero=1, not taken with zero=0 in the same cycle
    Opcode = 6'b110100;
    zero = 1'b1;
    cyc("beq_if", V_IF);
    cyc("beq_id", V_ID);
    chk("beq_taken", v(1,0,0,0,0,3'b001,1,0,0,1,1,0,2'b01,3'b101));
    zero = 1'b0;
    #1;
    cyc("beq_not", v(1,0,0,0,0,3'b001,1,0,0,1,1,0,2'b00,3'b101));

    // bne: taken with zero=0, not taken with zero=1
    Opcode = 6'b110101;
    cyc("bne_if", V_IF);
    cyc("bne_id", V_ID);
    chk("bne_taken", v(1,0,0,0,0,3'b001,1,0,0,1,1,0,2'b01,3'b101));
    zero = 1'b1;
    #1;
    cyc("bne_not", v(1,0,0,0,0,3'b001,1,0,0,1,1,0,2'b00,3'b101));

    // bltz: taken with sign=1 only
    Opcode = 6'b110110;
    zero = 1'b0;
    sign = 1'b1;
    cyc("bltz_if", V_IF);
    cyc("bltz_id", V_ID);
    chk("bltz_taken", v(1,0,0,0,0,3'b001,1,0,0,1,1,0,2'b01,3'b101));
    sign = 1'b0;
    #1;
    cyc("bltz_not", v(1,0,0,0,0,3'b001,1,0,0,1,1,0,2'b00,3'b101));

    // j: done in ID with PCSrc=10
    Opcode = 6'b111000;
    cyc("j_if", V_IF);
    cyc("j_id", v(1,0,0,0,0,3'b000,0,0,0,1,1,0,2'b10,3'b001));

    // undefined opcode behaves as a NOP
    Opcode = 6'b001111;
    cyc("nop_if", V_IF);
    cyc("nop_id", v(1,0,0,0,0,3'b000,0,0,0,1,1,0,2'b00,3'b001));

    // sll: shift amount on A, rd destination
    Opcode = 6'b011000;
    cyc("sll_if",  V_IF);
    cyc("sll_id",  V_ID);
    cyc("sll_exe", v(0,0,0,1,0,3'b010,0,0,0,1,1,0,2'b00,3'b110));
    cyc("sll_wb",  v(1,0,0,1,0,3'b010,0,1,1,1,1,0,2'b00,3'b111));

    // slti: immediate on B, sign-extended, rt destination
    Opcode = 6'b100111;
    cyc("slti_if",  V_IF);
    cyc("slti_id",  V_ID);
    cyc("slti_exe", v(0,0,0,0,1,3'b101,1,0,0,1,1,0,2'b00,3'b110));
    cyc("slti_wb",  v(1,0,0,0,1,3'b101,1,0,1,1,1,0,2'b00,3'b111));

    // andi: immediate on B, zero-extended
    Opcode = 6'b010001;
    cyc("andi_if",  V_IF);
    cyc("andi_id",  V_ID);
    cyc("andi_exe", v(0,0,0,0,1,3'b100,0,0,0,1,1,0,2'b00,3'b110));
    cyc("andi_wb",  v(1,0,0,0,1,3'b100,0,0,1,1,1,0,2'b00,3'b111));

    // lw interrupted by Reset during WB_LD
    Opcode = 6'b110001;
    cyc("lwr_if",  V_IF);
    cyc("lwr_id",  V_ID);
    cyc("lwr_exe", v(0,0,0,0,1,3'b000,1,0,0,1,1,0,2'b00,3'b010));
    cyc("lwr_mem", v(0,0,0,0,1,3'b000,1,0,0,0,1,0,2'b00,3'b011));
    chk("lwr_wb",  v(1,0,0,0,0,3'b000,0,0,1,0,1,1,2'b00,3'b100));
    Reset = 1'b0;
    #1;
    cyc("lwr_rst_now", V_IDLE);
    chk("lwr_rst_edge", V_IDLE);
    Reset = 1'b1;
    #1;

    // halt: enters HALT after ID and stalls with PCWre low
    Opcode = 6'b111111;
    cyc("halt_if", V_IF);
    cyc("halt_id", V_ID);
    for (int i = 0; i < 22; i++) begin
      cyc("halt_stall", V_ID);
    end
    Opcode = 6'b000000;
    #1;
    chk("halt_opcode_chg", V_ID);

    // Reset releases HALT back to IF
    Reset = 1'b0;
    #1;
    cyc("halt_rst", V_IDLE);
    Reset = 1'b1;
    #1;
    cyc("halt_exit_if", V_IF);
    chk("halt_exit_id", V_ID);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
